serial_add_ctrl: RTL

Sequencer that performs a WIDTH-bit addition on a single external 1-bit full adder (a, b, cin -> sum, cout), one bit per clock, LSB first. It latches the operands on a start pulse, drives the full-adder inputs from shift registers, and feeds cout back as the next carry. It collects sum bits into a result register and signals completion with a one-cycle done pulse. It sits between a requesting block and the shared full-adder cell.

---
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: drives a shared external 1-bit full adder LSB first.
// Optional SERIAL_ADD_OVF_EN adds an ovf output (signed two's-complement overflow).
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_out,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          // Accepting straight out of DONE gives back-to-back operations.
          if (start) begin
            a_sh_q  <= op_a;
            b_sh_q  <= op_b;
            carry_q <= cin_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          result_q <= {fa_sum, result_q[WIDTH-1:1]};
          carry_q  <= fa_cout;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            cout_q  <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= carry_q ^ fa_cout;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // busy_q mirrors RUN, so the adder inputs are quiet outside an operation.
  assign fa_a     = busy_q & a_sh_q[0];
  assign fa_b     = busy_q & b_sh_q[0];
  assign fa_cin   = busy_q & carry_q;

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout_out = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf      = ovf_q;
`endif

endmodule
